// File: rtl/decode_pkg.sv
// Shared opcodes, format enum and decoded-bundle type for the RV32I/E decode stage.
// DECODE_RV32M_EN adds the is_muldiv bundle field.
package decode_pkg;

  localparam int unsigned XLEN_MAX   = 64;
  localparam int unsigned REG_AW_MAX = 5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  // pc/imm sized for the widest datapath; the stage truncates to its XLEN
  typedef struct packed {
    logic [XLEN_MAX-1:0]   pc;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_AW_MAX-1:0] rs1, rs2, rd;
    logic                  rs1_en, rs2_en, rd_we;
    logic [XLEN_MAX-1:0]   imm;
    fmt_e                  fmt;
    logic                  ebreak, ecall, illegal;
`ifdef DECODE_RV32M_EN
    logic                  is_muldiv;
`endif
  } dec_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake and execute-side decoded bundle of decode_stage.
// is_muldiv exists only when DECODE_RV32M_EN is defined.
interface decode_stage_if import decode_pkg::*; #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) ();
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       inst;
  logic [XLEN-1:0]   pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              rs1_en, rs2_en, rd_we;
  logic [XLEN-1:0]   imm;
  fmt_e              fmt;
  logic              ebreak, ecall, illegal;
`ifdef DECODE_RV32M_EN
  logic              is_muldiv;
`endif

  modport master (
    output flush, in_valid, inst, pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
           rs1_en, rs2_en, rd_we, imm, fmt, ebreak, ecall, illegal
`ifdef DECODE_RV32M_EN
         , is_muldiv
`endif
  );

  modport slave (
    input  flush, in_valid, inst, pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
           rs1_en, rs2_en, rd_we, imm, fmt, ebreak, ecall, illegal
`ifdef DECODE_RV32M_EN
         , is_muldiv
`endif
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I/E instruction decoder producing a dec_bundle_t.
// DECODE_RV32M_EN makes OP with funct7 = 0x01 legal and sets is_muldiv.
module decode_comb import decode_pkg::*; #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output dec_bundle_t     dec_c
);
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic       use_rd, use_rs1, use_rs2, known, bad_fn, bad_reg, illegal;
  fmt_e       fmt;
  logic [XLEN_MAX-1:0] imm;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd_f   = inst[11:7];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];

  function automatic logic reg_fits(input logic [4:0] idx);
    return (idx >> REG_AW) == 5'd0;
  endfunction

  // Format, operand usage and funct-field legality per opcode
  always_comb begin
    fmt     = FMT_NONE;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    known   = 1'b1;
    bad_fn  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin fmt = FMT_U; use_rd = 1'b1; end
      OPC_JAL:            begin fmt = FMT_J; use_rd = 1'b1; end
      OPC_JALR, OPC_LOAD: begin fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH:         begin fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_STORE:          begin fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM: begin
        fmt     = FMT_I;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        if (funct3 == 3'b001)      bad_fn = funct7 != 7'h00;
        else if (funct3 == 3'b101) bad_fn = !(funct7 == 7'h00 || funct7 == 7'h20);
      end
      OPC_OP: begin
        fmt     = FMT_R;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (funct7)
          7'h00:   bad_fn = 1'b0;
          7'h20:   bad_fn = !(funct3 == 3'b000 || funct3 == 3'b101);
`ifdef DECODE_RV32M_EN
          7'h01:   bad_fn = 1'b0;
`endif
          default: bad_fn = 1'b1;
        endcase
      end
      OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_NONE;
      default: known = 1'b0;
    endcase
  end

  assign bad_reg = (use_rd  && !reg_fits(rd_f))  ||
                   (use_rs1 && !reg_fits(rs1_f)) ||
                   (use_rs2 && !reg_fits(rs2_f));
  assign illegal = !known || (inst[1:0] != 2'b11) || bad_fn || bad_reg;

  // Immediate reassembly, sign-extended from inst[31]
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN_MAX-12){inst[31]}}, inst[31:20]};
      FMT_S: imm = {{(XLEN_MAX-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{(XLEN_MAX-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {{(XLEN_MAX-32){inst[31]}}, inst[31:12], 12'b0};
      FMT_J: imm = {{(XLEN_MAX-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    dec_c         = '0;
    dec_c.pc      = XLEN_MAX'(pc);
    dec_c.opcode  = opcode;
    dec_c.funct3  = funct3;
    dec_c.funct7  = funct7;
    dec_c.rs1     = (use_rs1 && !illegal) ? rs1_f : 5'd0;
    dec_c.rs2     = (use_rs2 && !illegal) ? rs2_f : 5'd0;
    dec_c.rd      = (use_rd  && !illegal) ? rd_f  : 5'd0;
    dec_c.rs1_en  = use_rs1 && !illegal;
    dec_c.rs2_en  = use_rs2 && !illegal;
    dec_c.rd_we   = use_rd && !illegal && (rd_f != 5'd0);
    dec_c.imm     = imm;
    dec_c.fmt     = fmt;
    dec_c.ebreak  = inst == INST_EBREAK;
    dec_c.ecall   = inst == INST_ECALL;
    dec_c.illegal = illegal;
`ifdef DECODE_RV32M_EN
    dec_c.is_muldiv = (opcode == OPC_OP) && (funct7 == 7'h01) && !illegal;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/E decode stage: decode_comb feeding a 2-entry (main + skid) buffer.
// Define DECODE_RV32M_EN to accept M-extension ops and expose is_muldiv.
module decode_stage import decode_pkg::*; #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e      state;
  dec_bundle_t dec_c, main_q, skid_q;
  logic        out_valid_q, in_ready_q;
  logic        accept, drain;

  decode_comb #(.XLEN(XLEN), .REG_AW(REG_AW)) u_comb (
    .inst  (bus.inst),
    .pc    (bus.pc),
    .dec_c (dec_c)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  // Buffer occupancy; in_ready/out_valid are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (bus.flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= accept;
          if (accept) begin
            main_q <= dec_c;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= dec_c;
          end else if (accept) begin
            skid_q     <= dec_c;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = XLEN'(main_q.pc);
  assign bus.opcode    = main_q.opcode;
  assign bus.funct3    = main_q.funct3;
  assign bus.funct7    = main_q.funct7;
  assign bus.rs1       = REG_AW'(main_q.rs1);
  assign bus.rs2       = REG_AW'(main_q.rs2);
  assign bus.rd        = REG_AW'(main_q.rd);
  assign bus.rs1_en    = main_q.rs1_en;
  assign bus.rs2_en    = main_q.rs2_en;
  assign bus.rd_we     = main_q.rd_we;
  assign bus.imm       = XLEN'(main_q.imm);
  assign bus.fmt       = main_q.fmt;
  assign bus.ebreak    = main_q.ebreak;
  assign bus.ecall     = main_q.ecall;
  assign bus.illegal   = main_q.illegal;
`ifdef DECODE_RV32M_EN
  assign bus.is_muldiv = main_q.is_muldiv;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32I (REG_AW=5) and RV32E (REG_AW=4) instances driven in lockstep
// against a FIFO-of-decoded-entries reference model.
module tb_decode_stage;
  import decode_pkg::*;

`ifdef DECODE_RV32M_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_en, rs2_en, rd_we;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        eb, ec, ill, md;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   started = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .REG_AW(5)) ia ();
  decode_stage_if #(.XLEN(32), .REG_AW(4)) ib ();

  decode_stage #(.XLEN(32), .REG_AW(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  decode_stage #(.XLEN(32), .REG_AW(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: register usage follows from the instruction format
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] p, input int regaw);
    exp_t e;
    fmt_e fm;
    bit   known, bad, urd, urs1, urs2;
    int   lim;
    logic [6:0] op, f7;
    logic [2:0] f3;
    e = '0;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e.pc = p; e.op = op; e.f3 = f3; e.f7 = f7;
    fm = FMT_NONE; known = 1'b1; bad = 1'b0;
    case (op)
      7'h37, 7'h17:        fm = FMT_U;
      7'h6F:               fm = FMT_J;
      7'h67, 7'h03, 7'h13: fm = FMT_I;
      7'h63:               fm = FMT_B;
      7'h23:               fm = FMT_S;
      7'h33:               fm = FMT_R;
      7'h0F, 7'h73:        fm = FMT_NONE;
      default:             known = 1'b0;
    endcase
    if (op == 7'h33) begin
      if (f7 == 7'h20)      bad = !(f3 == 3'd0 || f3 == 3'd5);
      else if (f7 == 7'h01) bad = !MULDIV;
      else                  bad = f7 != 7'h00;
    end
    if (op == 7'h13 && f3 == 3'd1) bad = f7 != 7'h00;
    if (op == 7'h13 && f3 == 3'd5) bad = !(f7 == 7'h00 || f7 == 7'h20);
    urd  = fm inside {FMT_R, FMT_I, FMT_U, FMT_J};
    urs1 = fm inside {FMT_R, FMT_I, FMT_S, FMT_B};
    urs2 = fm inside {FMT_R, FMT_S, FMT_B};
    lim = 1 << regaw;
    if (urd  && int'(ins[11:7])  >= lim) bad = 1'b1;
    if (urs1 && int'(ins[19:15]) >= lim) bad = 1'b1;
    if (urs2 && int'(ins[24:20]) >= lim) bad = 1'b1;
    e.ill = !known || ins[1:0] != 2'b11 || bad;
    e.fmt = fm;
    case (fm)
      FMT_I: e.imm = 32'($signed(ins) >>> 20);
      FMT_S: e.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | 32'(ins[11:7]);
      FMT_B: e.imm = (ins[31] ? 32'hFFFF_F000 : 32'h0) | (32'(ins[7]) << 11)
                   | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      FMT_U: e.imm = ins & 32'hFFFF_F000;
      FMT_J: e.imm = (ins[31] ? 32'hFFF0_0000 : 32'h0) | (ins & 32'h000F_F000)
                   | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: e.imm = 32'h0;
    endcase
    e.rs1_en = urs1 && !e.ill;
    e.rs2_en = urs2 && !e.ill;
    e.rd_we  = urd && !e.ill && ins[11:7] != 5'd0;
    e.rs1 = e.rs1_en ? ins[19:15] : 5'd0;
    e.rs2 = e.rs2_en ? ins[24:20] : 5'd0;
    e.rd  = (urd && !e.ill) ? ins[11:7] : 5'd0;
    e.eb = ins == 32'h0010_0073;
    e.ec = ins == 32'h0000_0073;
    e.md = MULDIV && op == 7'h33 && f7 == 7'h01 && !e.ill;
    return e;
  endfunction

  function automatic exp_t obs_a();
    exp_t o;
    o = '0;
    o.pc = ia.out_pc; o.op = ia.opcode; o.f3 = ia.funct3; o.f7 = ia.funct7;
    o.rs1 = ia.rs1; o.rs2 = ia.rs2; o.rd = ia.rd;
    o.rs1_en = ia.rs1_en; o.rs2_en = ia.rs2_en; o.rd_we = ia.rd_we;
    o.imm = ia.imm; o.fmt = ia.fmt; o.eb = ia.ebreak; o.ec = ia.ecall; o.ill = ia.illegal;
`ifdef DECODE_RV32M_EN
    o.md = ia.is_muldiv;
`endif
    return o;
  endfunction

  function automatic exp_t obs_b();
    exp_t o;
    o = '0;
    o.pc = ib.out_pc; o.op = ib.opcode; o.f3 = ib.funct3; o.f7 = ib.funct7;
    o.rs1 = 5'(ib.rs1); o.rs2 = 5'(ib.rs2); o.rd = 5'(ib.rd);
    o.rs1_en = ib.rs1_en; o.rs2_en = ib.rs2_en; o.rd_we = ib.rd_we;
    o.imm = ib.imm; o.fmt = ib.fmt; o.eb = ib.ebreak; o.ec = ib.ecall; o.ill = ib.illegal;
`ifdef DECODE_RV32M_EN
    o.md = ib.is_muldiv;
`endif
    return o;
  endfunction

  task automatic compare();
    check("a_valid", 128'(ia.out_valid), 128'(qa.size() != 0));
    check("a_ready", 128'(ia.in_ready), 128'(started && qa.size() < 2));
    if (qa.size() != 0) check("a_bundle", 128'(obs_a()), 128'(qa[0]));
    check("b_valid", 128'(ib.out_valid), 128'(qb.size() != 0));
    check("b_ready", 128'(ib.in_ready), 128'(started && qb.size() < 2));
    if (qb.size() != 0) check("b_bundle", 128'(obs_b()), 128'(qb[0]));
  endtask

  // One clock: drive both DUTs, advance the FIFO model, check #1 after the edge
  task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] p,
                      input bit ordy, input bit fl);
    bit acc, drn;
    ia.in_valid = iv; ia.inst = ins; ia.pc = p; ia.out_ready = ordy; ia.flush = fl;
    ib.in_valid = iv; ib.inst = ins; ib.pc = p; ib.out_ready = ordy; ib.flush = fl;
    acc = iv && started && qa.size() < 2;
    drn = ordy && qa.size() != 0;
    @(posedge clk);
    if (fl) begin
      qa.delete(); qb.delete();
    end else begin
      if (drn) begin void'(qa.pop_front()); void'(qb.pop_front()); end
      if (acc) begin qa.push_back(ref_dec(ins, p, 5)); qb.push_back(ref_dec(ins, p, 4)); end
    end
    started = 1'b1;
    #1;
    compare();
  endtask

  task automatic do_reset();
    ia.in_valid = 1'b0; ia.flush = 1'b0; ia.out_ready = 1'b0; ia.inst = '0; ia.pc = '0;
    ib.in_valid = 1'b0; ib.flush = 1'b0; ib.out_ready = 1'b0; ib.inst = '0; ib.pc = '0;
    rst_n = 1'b0;
    #1;
    check("rst_valid_a", 128'(ia.out_valid), 128'(0));
    check("rst_valid_b", 128'(ib.out_valid), 128'(0));
    qa.delete(); qb.delete();
    started = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bundle_a", 128'(obs_a()), 128'(0));
    check("rst_ready_a", 128'(ia.in_ready), 128'(0));
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h01};
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = r;
      1: r = ($urandom_range(0, 1) != 0) ? 32'h0010_0073 : 32'h0000_0073;
      default: begin
        r[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) != 0) r[31:25] = f7s[$urandom_range(0, 2)];
      end
    endcase
    return r;
  endfunction

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
  endtask

  initial begin
    #2;
    do_reset();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0);
    check("addi_valid", 128'(ia.out_valid), 128'(1));
    check("addi_rd", 128'(ia.rd), 128'(1));
    check("addi_rs1", 128'(ia.rs1), 128'(0));
    check("addi_imm", 128'(ia.imm), 128'(32'hFFFF_FFFF));
    check("addi_fmt", 128'(ia.fmt), 128'(FMT_I));
    check("addi_rd_we", 128'(ia.rd_we), 128'(1));
    check("addi_rs2_en", 128'(ia.rs2_en), 128'(0));

    step(1'b1, 32'h0010_0073, 32'h104, 1'b1, 1'b0);
    check("ebreak", 128'(ia.ebreak), 128'(1));
    check("ebreak_ecall", 128'(ia.ecall), 128'(0));
    check("ebreak_illegal", 128'(ia.illegal), 128'(0));
    step(1'b1, 32'h0000_0073, 32'h108, 1'b1, 1'b0);
    check("ecall", 128'(ia.ecall), 128'(1));
    step(1'b1, 32'h0080_006F, 32'h10C, 1'b1, 1'b0);
    check("jal_imm", 128'(ia.imm), 128'(8));
    check("jal_rd_we", 128'(ia.rd_we), 128'(0));

    step(1'b1, 32'h0220_80B3, 32'h110, 1'b1, 1'b0);
`ifdef DECODE_RV32M_EN
    check("mul_illegal", 128'(ia.illegal), 128'(0));
    check("mul_muldiv", 128'(ia.is_muldiv), 128'(1));
`else
    check("mul_illegal", 128'(ia.illegal), 128'(1));
    check("mul_rd_we", 128'(ia.rd_we), 128'(0));
`endif

    step(1'b1, 32'h0100_0093, 32'h114, 1'b1, 1'b0);
    check("rv32e_x1_illegal", 128'(ib.illegal), 128'(0));
    check("rv32e_x1_rd", 128'(ib.rd), 128'(1));
    step(1'b1, 32'h01F0_0813, 32'h118, 1'b1, 1'b0);
    check("rv32e_x16_illegal", 128'(ib.illegal), 128'(1));
    check("rv32i_x16_illegal", 128'(ia.illegal), 128'(0));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h0010_0093, 32'h200, 1'b0, 1'b0);
    check("bb_first_pc", 128'(ia.out_pc), 128'(32'h200));
    step(1'b1, 32'h0020_0093, 32'h204, 1'b0, 1'b0);
    check("bb_full_ready", 128'(ia.in_ready), 128'(0));
    step(1'b1, 32'h0030_0093, 32'h208, 1'b0, 1'b0);
    check("bb_hold_pc", 128'(ia.out_pc), 128'(32'h200));
    step(1'b1, 32'h0030_0093, 32'h208, 1'b1, 1'b0);
    check("bb_second_pc", 128'(ia.out_pc), 128'(32'h204));
    step(1'b1, 32'h0030_0093, 32'h208, 1'b1, 1'b0);
    check("bb_third_pc", 128'(ia.out_pc), 128'(32'h208));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bb_drained", 128'(ia.out_valid), 128'(0));

    step(1'b1, 32'h0010_0093, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 32'h404, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0093, 32'h408, 1'b1, 1'b1);
    check("flush_valid", 128'(ia.out_valid), 128'(0));
    check("flush_ready", 128'(ia.in_ready), 128'(1));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush_dropped", 128'(ia.out_valid), 128'(0));

    rand_run(3000);

    step(1'b1, 32'h0010_0093, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 32'h504, 1'b0, 1'b0);
    do_reset();
    rand_run(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
